// File: rtl/core_dispatch_pkg.sv
// Shared CPU7 dispatch constants: word tags, literal geometry, FSM states.
// Imported by the dispatch front end and its literal accumulator.
package core_dispatch_pkg;

    localparam int CHUNK_W = 14;
    localparam int VALUE_W = 56;

    typedef enum logic [1:0] {
        TAG_INSTR    = 2'b00,
        TAG_LIT_MORE = 2'b01,
        TAG_LIT_LAST = 2'b10,
        TAG_HALT     = 2'b11
    } tag_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_ISSUE,
        S_GUARD,
        S_HALT
    } state_e;

endpackage

// File: rtl/core_dispatch_lit_accum.sv
// Literal accumulator: shifts 14-bit chunks in MSB-first and counts them.
// full flags that one more LIT_MORE chunk would overflow the 56-bit push.
module core_dispatch_lit_accum
    import core_dispatch_pkg::*;
#(
    parameter int LIT_CHUNKS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shift_en,
    input  logic               clear_en,
    input  logic [CHUNK_W-1:0] chunk,
    output logic [VALUE_W-1:0] joined,
    output logic               full
);

    localparam int CNT_W = (LIT_CHUNKS > 1) ? $clog2(LIT_CHUNKS) : 1;

    logic [VALUE_W-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               unused_acc_top;

    // Top chunk falls off the end: the push is truncated to VALUE_W bits.
    assign joined = {acc[VALUE_W-CHUNK_W-1:0], chunk};
    assign full   = (cnt == CNT_W'(LIT_CHUNKS - 1));
    assign unused_acc_top = ^acc[VALUE_W-1:VALUE_W-CHUNK_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear_en) begin
            acc <= '0;
            cnt <= '0;
        end else if (shift_en) begin
            acc <= joined;
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/core_dispatch.sv
// CPU7 fetch/dispatch front end: fetches tagged code words at core pcp,
// assembles literals, issues push/instr pulses gated on core idle.
module core_dispatch
    import core_dispatch_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int LIT_CHUNKS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [15:0]        mem_data,
    input  logic [27:0]        core_pcp,
    input  logic               core_idle,
    output logic [VALUE_W-1:0] push_value,
    output logic               push_en,
    output logic [CHUNK_W-1:0] instr,
    output logic               instr_en,
    output logic               pcp_step_en,
    output logic               halted,
    output logic               error
);

    state_e             state_q, state_d;
    tag_e               tag;
    logic [CHUNK_W-1:0] payload;
    logic [VALUE_W-1:0] joined;
    logic               full;
    logic               shift_en, clear_en;
    logic               kind_q, kind_d;
    logic               mem_rd_d, push_en_d, instr_en_d, step_d;
    logic               halted_d, error_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [VALUE_W-1:0] push_value_d;
    logic [CHUNK_W-1:0] instr_d;
    logic               unused_pcp_hi;

    assign tag     = tag_e'(mem_data[15:14]);
    assign payload = mem_data[CHUNK_W-1:0];
    assign unused_pcp_hi = ^core_pcp[27:ADDR_W];

    core_dispatch_lit_accum #(
        .LIT_CHUNKS(LIT_CHUNKS)
    ) u_lit (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift_en(shift_en),
        .clear_en(clear_en),
        .chunk   (payload),
        .joined  (joined),
        .full    (full)
    );

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        mem_rd_d     = 1'b0;
        mem_addr_d   = mem_addr;
        push_value_d = push_value;
        push_en_d    = 1'b0;
        instr_d      = instr;
        instr_en_d   = 1'b0;
        step_d       = 1'b0;
        halted_d     = halted;
        error_d      = error;
        shift_en     = 1'b0;
        clear_en     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else begin
                    // A step pulse still in flight lands on this edge.
                    mem_rd_d   = 1'b1;
                    mem_addr_d = core_pcp[ADDR_W-1:0]
                               + ADDR_W'(pcp_step_en);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: state_d = S_DECODE;
            S_DECODE: begin
                unique case (tag)
                    TAG_HALT: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    TAG_LIT_MORE: begin
                        if (full) begin
                            error_d  = 1'b1;
                            halted_d = 1'b1;
                            state_d  = S_HALT;
                        end else begin
                            shift_en = 1'b1;
                            step_d   = 1'b1;
                            state_d  = S_FETCH;
                        end
                    end
                    TAG_LIT_LAST: begin
                        push_value_d = joined;
                        clear_en     = 1'b1;
                        kind_d       = 1'b1;
                        step_d       = 1'b1;
                        state_d      = S_ISSUE;
                    end
                    TAG_INSTR: begin
                        instr_d = payload;
                        kind_d  = 1'b0;
                        step_d  = 1'b1;
                        state_d = S_ISSUE;
                    end
                endcase
            end
            S_ISSUE: begin
                if (core_idle) begin
                    push_en_d  = kind_q;
                    instr_en_d = !kind_q;
                    state_d    = S_GUARD;
                end
            end
            S_GUARD: state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            kind_q      <= 1'b0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            push_value  <= '0;
            push_en     <= 1'b0;
            instr       <= '0;
            instr_en    <= 1'b0;
            pcp_step_en <= 1'b0;
            halted      <= 1'b0;
            error       <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            mem_rd      <= mem_rd_d;
            mem_addr    <= mem_addr_d;
            push_value  <= push_value_d;
            push_en     <= push_en_d;
            instr       <= instr_d;
            instr_en    <= instr_en_d;
            pcp_step_en <= step_d;
            halted      <= halted_d;
            error       <= error_d;
        end
    end

endmodule

// File: tb/tb_core_dispatch.sv
// Bench for core_dispatch: ROM + core model, scoreboard of expected
// push/instr pulses popped as the DUT issues them.
module tb_core_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic [15:0] mem_data;
    logic [27:0] core_pcp;
    logic        core_idle;
    logic [55:0] push_value;
    logic        push_en;
    logic [13:0] instr;
    logic        instr_en;
    logic        pcp_step_en;
    logic        halted;
    logic        error;

    typedef struct {
        bit          is_push;
        logic [55:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] rom[4096];
    int          busy;
    logic        force_busy;
    int          cyc;
    int          n_tests, n_fail;
    int          push_cnt, instr_cnt, rd_count;
    int          rd_cycle, en_cycle;

    always #5 clk = ~clk;

    core_dispatch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .core_pcp   (core_pcp),
        .core_idle  (core_idle),
        .push_value (push_value),
        .push_en    (push_en),
        .instr      (instr),
        .instr_en   (instr_en),
        .pcp_step_en(pcp_step_en),
        .halted     (halted),
        .error      (error)
    );

    assign core_idle = (busy == 0) && !force_busy;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd) mem_data <= rom[mem_addr];
        if (!rst_n) begin
            core_pcp <= '0;
            busy     <= 0;
        end else begin
            if (pcp_step_en) core_pcp <= core_pcp + 28'd1;
            if (push_en || instr_en) busy <= 3;
            else if (busy != 0) busy <= busy - 1;
        end
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (push_en || instr_en || pcp_step_en)
            check("pulse_excl",
                  64'(push_en) + 64'(instr_en) + 64'(pcp_step_en), 1);
        if (mem_rd) begin
            rd_count++;
            if (rd_cycle < 0) rd_cycle = cyc;
        end
        if (instr_en) begin
            instr_cnt++;
            en_cycle = cyc;
            if (sb.size() == 0) begin
                check("sb_unexp_instr", 0, 1);
            end else begin
                e = sb.pop_front();
                check("sb_kind_instr", 64'(e.is_push), 0);
                check("instr_val", 64'(instr), 64'(e.val));
            end
        end
        if (push_en) begin
            push_cnt++;
            if (sb.size() == 0) begin
                check("sb_unexp_push", 0, 1);
            end else begin
                e = sb.pop_front();
                check("sb_kind_push", 64'(e.is_push), 1);
                check("push_val", 64'(push_value), 64'(e.val));
            end
        end
    end

    task automatic expect_ev(input bit is_push, input logic [55:0] v);
        exp_t e;
        e.is_push = is_push;
        e.val     = v;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        run        = 1'b0;
        force_busy = 1'b0;
        for (int i = 0; i < 4096; i++) rom[i] = 16'h0000;
        sb.delete();
        repeat (2) @(negedge clk);
        push_cnt  = 0;
        instr_cnt = 0;
        rd_count  = 0;
        rd_cycle  = -1;
        en_cycle  = -1;
        rst_n     = 1'b1;
    endtask

    task automatic wait_halt(input int max);
        for (int i = 0; i < max && !halted; i++) @(negedge clk);
        check("halt_timeout", 64'(halted), 1);
    endtask

    task automatic wait_step(input int max);
        for (int i = 0; i < max && !pcp_step_en; i++) @(negedge clk);
        check("step_timeout", 64'(pcp_step_en), 1);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        mem_data = '0;
        do_reset();

        check("rst_mem_rd", 64'(mem_rd), 0);
        check("rst_addr", 64'(mem_addr), 0);
        check("rst_push_val", 64'(push_value), 0);
        check("rst_instr", 64'(instr), 0);
        check("rst_halted", 64'(halted), 0);
        check("rst_error", 64'(error), 0);

        // 1: single INSTR then HALT
        rom[0] = 16'h0123;
        rom[1] = 16'hC000;
        expect_ev(1'b0, 56'h0123);
        run = 1'b1;
        wait_halt(100);
        check("t1_instr_cnt", 64'(instr_cnt), 1);
        check("t1_pcp", 64'(core_pcp), 1);
        check("t1_lat_rd_en", 64'(en_cycle - rd_cycle), 3);
        check("t1_error", 64'(error), 0);
        check("t1_sb_empty", 64'(sb.size()), 0);

        // 2: three-chunk literal
        do_reset();
        rom[0] = 16'h4001;
        rom[1] = 16'h4002;
        rom[2] = 16'h8003;
        rom[3] = 16'hC000;
        expect_ev(1'b1, 56'h0000_0010_008003);
        run = 1'b1;
        wait_halt(100);
        check("t2_push_cnt", 64'(push_cnt), 1);
        check("t2_instr_cnt", 64'(instr_cnt), 0);
        check("t2_pcp", 64'(core_pcp), 3);
        check("t2_sb_empty", 64'(sb.size()), 0);

        // 3: literal overflow on 4th LIT_MORE
        do_reset();
        rom[0] = 16'h4001;
        rom[1] = 16'h4002;
        rom[2] = 16'h4003;
        rom[3] = 16'h4004;
        rom[4] = 16'h8005;
        run = 1'b1;
        wait_halt(100);
        check("t3_error", 64'(error), 1);
        check("t3_pcp", 64'(core_pcp), 3);
        repeat (10) @(negedge clk);
        check("t3_push_cnt", 64'(push_cnt), 0);

        // 4: INSTR held off by busy core
        do_reset();
        rom[0] = 16'h0055;
        rom[1] = 16'hC000;
        expect_ev(1'b0, 56'h55);
        force_busy = 1'b1;
        run = 1'b1;
        repeat (10) @(negedge clk);
        check("t4_held", 64'(instr_cnt), 0);
        force_busy = 1'b0;
        wait_halt(100);
        check("t4_instr_cnt", 64'(instr_cnt), 1);
        check("t4_sb_empty", 64'(sb.size()), 0);

        // 5: two INSTRs then HALT, no fetch afterwards
        do_reset();
        rom[0] = 16'h0011;
        rom[1] = 16'h0022;
        rom[2] = 16'hC000;
        expect_ev(1'b0, 56'h11);
        expect_ev(1'b0, 56'h22);
        run = 1'b1;
        wait_halt(100);
        check("t5_instr_cnt", 64'(instr_cnt), 2);
        check("t5_pcp", 64'(core_pcp), 2);
        rd_count = 0;
        repeat (10) @(negedge clk);
        check("t5_no_rd", 64'(rd_count), 0);
        check("t5_halted", 64'(halted), 1);

        // 6: run dropped mid-literal
        do_reset();
        rom[0] = 16'h6AAA;
        rom[1] = 16'h9555;
        rom[2] = 16'hC000;
        expect_ev(1'b1, 56'hAAA9555);
        run = 1'b1;
        wait_step(50);
        run = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_paused_push", 64'(push_cnt), 0);
        check("t6_paused_pcp", 64'(core_pcp), 1);
        run = 1'b1;
        wait_halt(100);
        check("t6_push_cnt", 64'(push_cnt), 1);
        check("t6_sb_empty", 64'(sb.size()), 0);

        // 7: reset while waiting in issue
        do_reset();
        rom[0] = 16'h8042;
        force_busy = 1'b1;
        run = 1'b1;
        wait_step(50);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        @(negedge clk);
        check("t7_push_val", 64'(push_value), 0);
        check("t7_push_en", 64'(push_en), 0);
        check("t7_mem_rd", 64'(mem_rd), 0);
        check("t7_step", 64'(pcp_step_en), 0);
        rst_n = 1'b1;
        force_busy = 1'b0;
        repeat (10) @(negedge clk);
        check("t7_no_push", 64'(push_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
